// File: rtl/fir_stream_tx.sv
// fir_stream_tx
// Stream transmitter feeding the FIR filter input (DOUT/VOUT drive DIN/VIN).
// The host pushes samples into an internal FIFO. A START pulse launches a
// burst of NSAMP samples with GAP idle cycles after each emitted sample.
// The block reports completion with a one-cycle DONE pulse. It counts cycles
// where a sample was due but the FIFO was empty.
//
// Ports:
//   CLK       in   1    clock, rising edge
//   RST       in   1    asynchronous active-high reset
//   WR_EN     in   1    host write strobe, accepted when FULL=0
//   WR_DATA   in   DW   sample to push
//   FULL      out  1    FIFO holds DEPTH entries
//   EMPTY     out  1    FIFO holds no entries
//   START     in   1    burst start pulse, honoured only when idle
//   NSAMP     in   CW   burst length, sampled on START
//   GAP       in   4    idle cycles after each sample, sampled on START
//   DOUT      out  DW   registered sample to the filter
//   VOUT      out  1    registered DOUT valid
//   BUSY      out  1    burst in progress
//   DONE      out  1    one-cycle pulse when a burst completes
//   UNDERRUN  out  8    saturating count of starved cycles, cleared on START

module fir_stream_tx #(
  parameter int DW    = 11,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [DW-1:0] WR_DATA,
  output logic          FULL,
  output logic          EMPTY,
  input  logic          START,
  input  logic [CW-1:0] NSAMP,
  input  logic [3:0]    GAP,
  output logic [DW-1:0] DOUT,
  output logic          VOUT,
  output logic          BUSY,
  output logic          DONE,
  output logic [7:0]    UNDERRUN
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          empty_q;
  logic          push;
  logic          pop;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] dout_q;
  logic [DW-1:0] dout_d;
  logic          vout_q;
  logic          vout_d;
  logic          done_q;
  logic          done_d;
  logic [7:0]    underrun_q;
  logic [7:0]    underrun_d;
  logic [3:0]    gap_cnt_q;
  logic [3:0]    gap_cnt_d;
  logic [3:0]    gap_q;
  logic [3:0]    gap_d;
  logic [CW-1:0] sent_q;
  logic [CW-1:0] sent_d;
  logic [CW-1:0] sent_inc;
  logic [CW-1:0] nsamp_q;
  logic [CW-1:0] nsamp_d;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push = WR_EN && !full_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage carries no reset; only pointers and count define the contents.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

  // Flags are registered from the next count so they describe the FIFO
  // after the current edge. Pointers wrap naturally at power-of-two depth.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
    end
  end

  assign sent_inc = sent_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    vout_d     = 1'b0;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    gap_cnt_d  = gap_cnt_q;
    gap_d      = gap_q;
    sent_d     = sent_q;
    nsamp_d    = nsamp_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          nsamp_d    = NSAMP;
          gap_d      = GAP;
          sent_d     = '0;
          gap_cnt_d  = '0;
          underrun_d = '0;
          state_d    = (NSAMP == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else if (!empty_q) begin
          pop       = 1'b1;
          dout_d    = mem_q[rd_ptr_q];
          vout_d    = 1'b1;
          sent_d    = sent_inc;
          gap_cnt_d = gap_q;
          if (sent_inc == nsamp_q) begin
            state_d = ST_FIN;
          end
        end else if (underrun_q != 8'hFF) begin
          underrun_d = underrun_q + 8'd1;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      dout_q     <= '0;
      vout_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= '0;
      gap_cnt_q  <= '0;
      gap_q      <= '0;
      sent_q     <= '0;
      nsamp_q    <= '0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      vout_q     <= vout_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      gap_cnt_q  <= gap_cnt_d;
      gap_q      <= gap_d;
      sent_q     <= sent_d;
      nsamp_q    <= nsamp_d;
    end
  end

  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign DOUT     = dout_q;
  assign VOUT     = vout_q;
  assign BUSY     = (state_q == ST_RUN);
  assign DONE     = done_q;
  assign UNDERRUN = underrun_q;

endmodule

// File: doc/fir_stream_tx.md
Name: fir_stream_tx

Overview:
- Synthesizable stream transmitter that feeds the FIR input interface (DOUT/VOUT here drive the filter's DIN/VIN).
- The host writes samples into an internal FIFO. On START the block emits a programmed number of samples, one per cycle or with a programmable idle gap between samples.
- Exercises VIN deassertion and reports completion and underruns.
- It is the transmitting end of the same valid-qualified sample stream that the output sink receives.

Parameters:
- DW, 11, sample width in bits (matches the FIR datapath).
- DEPTH, 16, FIFO depth in samples; power of two, at least 2.
- CW, 16, width of the sample-count register.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR_EN  in  1  host write strobe; pushes WR_DATA when FULL=0.
- WR_DATA  in  DW  sample to push (two's complement, passed through unchanged).
- FULL  out  1  FIFO holds DEPTH entries.
- EMPTY  out  1  FIFO holds 0 entries.
- START  in  1  one-cycle pulse; begins a burst (honoured only in IDLE).
- NSAMP  in  CW  number of samples in the burst, sampled on START.
- GAP  in  4  idle cycles inserted after each emitted sample, sampled on START.
- DOUT  out  DW  sample to FIR DIN (registered).
- VOUT  out  1  DOUT valid, drives FIR VIN (registered).
- BUSY  out  1  high in RUN state.
- DONE  out  1  one-cycle pulse when the burst completes.
- UNDERRUN  out  8  saturating count of cycles where a sample was due but the FIFO was empty; cleared on START.

Behaviour:
- Reset (async, RST=1): FIFO emptied (pointers/count=0), state=IDLE, DOUT=0, VOUT=0, BUSY=0, DONE=0, UNDERRUN=0, gap counter=0, sent counter=0. Reset mid-burst abandons the burst; no DONE pulse is produced.
- FIFO:
  - Count-based FULL/EMPTY, both registered, reflecting the count after the current edge.
  - A write when FULL=0 is accepted. A write when FULL=1 is dropped, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full and not empty: count unchanged.
  - A push into an empty FIFO is poppable from the next cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, RUN, FIN.
  - IDLE: VOUT=0. On START, latch NSAMP and GAP, clear sent counter, gap counter and UNDERRUN. If NSAMP=0, go to FIN; otherwise go to RUN. START outside IDLE is ignored.
  - RUN, one of three cases per cycle:
    - Gap counter nonzero: decrement it; VOUT<=0.
    - Gap counter zero and FIFO non-empty: pop; DOUT<=head; VOUT<=1; sent++; gap counter<=latched GAP. If sent+1 = latched NSAMP, next state is FIN.
    - Gap counter zero and FIFO empty: VOUT<=0; UNDERRUN increments, saturating at 255. Remain in RUN; the stream resumes when data arrives.
  - FIN: DONE<=1 for exactly one cycle, VOUT<=0, then IDLE. BUSY=0 in FIN.
- Latency: a pop at edge k gives VOUT=1 with the sample on DOUT during cycle k+1 (registered).
  - With GAP=g and the FIFO never empty, VOUT is 1 for one cycle then 0 for g cycles, repeating.
  - GAP=0 gives back-to-back samples.
- DOUT holds its last emitted value while VOUT=0 and is not cleared between bursts.
- Host writes are accepted in every state, including during RUN.
- The DONE pulse lands on the cycle after the last VOUT=1 cycle.

Test Plan:
- Reset, write 5 samples (1, 2, -1 = 0x7FF, 1023, -1024 = 0x400), START with NSAMP=5, GAP=0 -> VOUT high for 5 consecutive cycles starting 2 cycles after START, DOUT = 1, 2, 0x7FF, 0x3FF, 0x400; DONE pulses once the cycle after; UNDERRUN=0.
- Preload 4 samples, NSAMP=4, GAP=2 -> VOUT pattern 1,0,0,1,0,0,1,0,0,1, then DONE; BUSY high throughout RUN.
- Write 16 samples -> FULL=1 after the 16th. A 17th write is dropped. Stream all 16 -> 17th value never appears; EMPTY=1 at end.
- Preload 2 samples, NSAMP=4, GAP=0, write 2 more 10 cycles later -> UNDERRUN=8 at DONE; all 4 samples emitted in order; no DONE before the 4th.
- START with NSAMP=0 -> DONE pulse 2 cycles after START, VOUT stays 0. START pulse during RUN -> ignored; NSAMP is not relatched.
- Assert RST asynchronously (mid-cycle) after 3 of 8 samples are sent -> VOUT=0, EMPTY=1, BUSY=0 immediately, no DONE. After release, a new burst of 2 samples runs normally.
